// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath/memory.
// The controller takes the master view; the datapath side takes the slave view.
interface mips_mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       PCWrite;
  logic       PCWriteCon;
  logic       IorD;
  logic       mem_read;
  logic       mem_write;
  logic       IR_write;
  logic       RegDst;
  logic [1:0] RegWrDst;
  logic       reg_write;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] alu_op;
  logic [1:0] pc_src;

  modport master (
    input  opcode, func, zero,
    output PCWrite, PCWriteCon, IorD, mem_read, mem_write, IR_write,
           RegDst, RegWrDst, reg_write, ALUSrcA, ALUSrcB, alu_op, pc_src
  );

  modport slave (
    output opcode, func, zero,
    input  PCWrite, PCWriteCon, IorD, mem_read, mem_write, IR_write,
           RegDst, RegWrDst, reg_write, ALUSrcA, ALUSrcB, alu_op, pc_src
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: Moore outputs decoded from the state register,
// with func/opcode selecting the ALU operation in the execute states.
module mips_mc_controller (
  input logic                  clk,
  input logic                  rst,
  mips_mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_R_EXEC  = 4'd7,
    S_R_WB    = 4'd8,
    S_I_EXEC  = 4'd9,
    S_I_WB    = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_JAL     = 4'd13,
    S_JR      = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_e state_q, state_d;

  logic       pc_write_s, pc_write_con_s, iord_s, mem_read_s, mem_write_s;
  logic       ir_write_s, reg_dst_s, reg_write_s, alu_src_a_s;
  logic [1:0] reg_wr_dst_s, alu_src_b_s, pc_src_s;
  logic [2:0] alu_op_s;

  function automatic logic is_r_func(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: is_r_func = 1'b1;
      default:                                               is_r_func = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_alu = ALU_ADD;
    endcase
  endfunction

  // State register; reset parks the FSM in IDLE with every strobe low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unsupported instructions and stray encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE: begin
            if (is_r_func(bus.func)) begin
              state_d = S_R_EXEC;
            end else if (bus.func == FN_JR) begin
              state_d = S_JR;
            end else begin
              state_d = S_FETCH;
            end
          end
          OP_LW, OP_SW:     state_d = S_MEM_ADR;
          OP_BEQ:           state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEM_ADR: begin
        if (bus.opcode == OP_LW) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_MEM_RD:  state_d = S_MEM_WB;
      S_R_EXEC:  state_d = S_R_WB;
      S_I_EXEC:  state_d = S_I_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode; anything not named for a state stays low.
  always_comb begin
    pc_write_s     = 1'b0;
    pc_write_con_s = 1'b0;
    iord_s         = 1'b0;
    mem_read_s     = 1'b0;
    mem_write_s    = 1'b0;
    ir_write_s     = 1'b0;
    reg_dst_s      = 1'b0;
    reg_wr_dst_s   = 2'b00;
    reg_write_s    = 1'b0;
    alu_src_a_s    = 1'b0;
    alu_src_b_s    = 2'b00;
    alu_op_s       = ALU_ADD;
    pc_src_s       = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        ir_write_s  = 1'b1;
        alu_src_b_s = 2'b01;
        pc_write_s  = 1'b1;
      end
      S_DECODE:  alu_src_b_s = 2'b11;
      S_MEM_ADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_MEM_RD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        reg_wr_dst_s = 2'b01;
      end
      S_MEM_WR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = r_alu(bus.func);
      end
      S_R_WB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (bus.opcode == OP_SLTI) begin
          alu_op_s = ALU_SLT;
        end else begin
          alu_op_s = ALU_ADD;
        end
      end
      S_I_WB:    reg_write_s = 1'b1;
      S_BRANCH: begin
        alu_src_a_s    = 1'b1;
        alu_op_s       = ALU_SUB;
        pc_write_con_s = 1'b1;
        pc_src_s       = 2'b01;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        pc_src_s   = 2'b10;
      end
      // PC already holds PC+4 here, so $31 captures the return address as the jump loads.
      S_JAL: begin
        pc_write_s   = 1'b1;
        pc_src_s     = 2'b10;
        reg_write_s  = 1'b1;
        reg_wr_dst_s = 2'b10;
      end
      S_JR: begin
        pc_write_s = 1'b1;
        pc_src_s   = 2'b11;
      end
      default: begin
        pc_write_s = 1'b0;
      end
    endcase
  end

  assign bus.PCWrite    = pc_write_s;
  assign bus.PCWriteCon = pc_write_con_s;
  assign bus.IorD       = iord_s;
  assign bus.mem_read   = mem_read_s;
  assign bus.mem_write  = mem_write_s;
  assign bus.IR_write   = ir_write_s;
  assign bus.RegDst     = reg_dst_s;
  assign bus.RegWrDst   = reg_wr_dst_s;
  assign bus.reg_write  = reg_write_s;
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.pc_src     = pc_src_s;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for the multicycle MIPS controller: walks each instruction class
// cycle by cycle and compares the full control word against hand-derived values.
module tb_mips_mc_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mips_mc_controller_if bus ();

  mips_mc_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,PCWriteCon,IorD,mem_read,mem_write,IR_write,RegDst,RegWrDst[1:0],
  //  reg_write,ALUSrcA,ALUSrcB[1:0],alu_op[2:0],pc_src[1:0]}
  logic [17:0] obs_s;
  assign obs_s = {bus.PCWrite, bus.PCWriteCon, bus.IorD, bus.mem_read, bus.mem_write,
                  bus.IR_write, bus.RegDst, bus.RegWrDst, bus.reg_write, bus.ALUSrcA,
                  bus.ALUSrcB, bus.alu_op, bus.pc_src};

  localparam logic [17:0] W_ZERO    = 18'b0_0_0_0_0_0_0_00_0_0_00_000_00;
  localparam logic [17:0] W_FETCH   = 18'b1_0_0_1_0_1_0_00_0_0_01_000_00;
  localparam logic [17:0] W_DECODE  = 18'b0_0_0_0_0_0_0_00_0_0_11_000_00;
  localparam logic [17:0] W_MEM_ADR = 18'b0_0_0_0_0_0_0_00_0_1_10_000_00;
  localparam logic [17:0] W_MEM_RD  = 18'b0_0_1_1_0_0_0_00_0_0_00_000_00;
  localparam logic [17:0] W_MEM_WB  = 18'b0_0_0_0_0_0_0_01_1_0_00_000_00;
  localparam logic [17:0] W_MEM_WR  = 18'b0_0_1_0_1_0_0_00_0_0_00_000_00;
  localparam logic [17:0] W_R_ADD   = 18'b0_0_0_0_0_0_0_00_0_1_00_000_00;
  localparam logic [17:0] W_R_SUB   = 18'b0_0_0_0_0_0_0_00_0_1_00_001_00;
  localparam logic [17:0] W_R_AND   = 18'b0_0_0_0_0_0_0_00_0_1_00_010_00;
  localparam logic [17:0] W_R_OR    = 18'b0_0_0_0_0_0_0_00_0_1_00_011_00;
  localparam logic [17:0] W_R_SLT   = 18'b0_0_0_0_0_0_0_00_0_1_00_100_00;
  localparam logic [17:0] W_R_WB    = 18'b0_0_0_0_0_0_1_00_1_0_00_000_00;
  localparam logic [17:0] W_I_ADD   = 18'b0_0_0_0_0_0_0_00_0_1_10_000_00;
  localparam logic [17:0] W_I_SLT   = 18'b0_0_0_0_0_0_0_00_0_1_10_100_00;
  localparam logic [17:0] W_I_WB    = 18'b0_0_0_0_0_0_0_00_1_0_00_000_00;
  localparam logic [17:0] W_BRANCH  = 18'b0_1_0_0_0_0_0_00_0_1_00_001_01;
  localparam logic [17:0] W_JUMP    = 18'b1_0_0_0_0_0_0_00_0_0_00_000_10;
  localparam logic [17:0] W_JAL     = 18'b1_0_0_0_0_0_0_10_1_0_00_000_10;
  localparam logic [17:0] W_JR      = 18'b1_0_0_0_0_0_0_00_0_0_00_000_11;

  task automatic check(input string tag, input logic [17:0] exp);
    n_checks++;
    assert (obs_s === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs_s, exp);
    end
  endtask

  task automatic step(input string tag, input logic [17:0] exp);
    @(negedge clk);
    check(tag, exp);
  endtask

  // Check the FETCH cycle, then present the instruction fields decoded next.
  task automatic start(input string tag, input logic [5:0] op, input logic [5:0] fn);
    step(tag, W_FETCH);
    bus.opcode = op;
    bus.func   = fn;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    bus.opcode = 6'b000000;
    bus.func   = 6'b000000;
    bus.zero   = 1'b0;

    repeat (2) @(negedge clk);
    check("reset", W_ZERO);
    rst = 1'b1;

    start("sub_fetch", 6'b000000, 6'b100010);
    step("sub_decode", W_DECODE);
    step("sub_exec",   W_R_SUB);
    step("sub_wb",     W_R_WB);

    start("add_fetch", 6'b000000, 6'b100000);
    step("add_decode", W_DECODE);
    step("add_exec",   W_R_ADD);
    step("add_wb",     W_R_WB);

    start("and_fetch", 6'b000000, 6'b100100);
    step("and_decode", W_DECODE);
    step("and_exec",   W_R_AND);
    step("and_wb",     W_R_WB);

    start("or_fetch", 6'b000000, 6'b100101);
    step("or_decode", W_DECODE);
    step("or_exec",   W_R_OR);
    step("or_wb",     W_R_WB);

    start("slt_fetch", 6'b000000, 6'b101010);
    step("slt_decode", W_DECODE);
    step("slt_exec",   W_R_SLT);
    step("slt_wb",     W_R_WB);

    start("lw_fetch", 6'b100011, 6'b000000);
    step("lw_decode", W_DECODE);
    step("lw_adr",    W_MEM_ADR);
    step("lw_rd",     W_MEM_RD);
    step("lw_wb",     W_MEM_WB);

    start("sw_fetch", 6'b101011, 6'b000000);
    step("sw_decode", W_DECODE);
    step("sw_adr",    W_MEM_ADR);
    step("sw_wr",     W_MEM_WR);

    start("addi_fetch", 6'b001000, 6'b000000);
    step("addi_decode", W_DECODE);
    step("addi_exec",   W_I_ADD);
    step("addi_wb",     W_I_WB);

    start("slti_fetch", 6'b001010, 6'b000000);
    step("slti_decode", W_DECODE);
    step("slti_exec",   W_I_SLT);
    step("slti_wb",     W_I_WB);

    start("beq_fetch", 6'b000100, 6'b000000);
    step("beq_decode", W_DECODE);
    step("beq_branch", W_BRANCH);

    start("j_fetch", 6'b000010, 6'b000000);
    step("j_decode", W_DECODE);
    step("j_jump",   W_JUMP);

    start("jal_fetch", 6'b000011, 6'b000000);
    step("jal_decode", W_DECODE);
    step("jal_jal",    W_JAL);

    start("jr_fetch", 6'b000000, 6'b001000);
    step("jr_decode", W_DECODE);
    step("jr_jr",     W_JR);

    start("badop_fetch", 6'b111111, 6'b000000);
    step("badop_decode", W_DECODE);

    start("badfn_fetch", 6'b000000, 6'b000001);
    step("badfn_decode", W_DECODE);

    // Reset pulse in the middle of a load: the write-back cycle must never appear.
    start("rstlw_fetch", 6'b100011, 6'b000000);
    step("rstlw_decode", W_DECODE);
    step("rstlw_adr",    W_MEM_ADR);
    step("rstlw_rd",     W_MEM_RD);
    #1 rst = 1'b0;
    #1 check("rstlw_async_zero", W_ZERO);
    #4 rst = 1'b1;
    step("rstlw_idle",  W_ZERO);
    step("rstlw_fetch2", W_FETCH);
    bus.opcode = 6'b000010;
    step("rstlw_decode2", W_DECODE);
    step("rstlw_jump",    W_JUMP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multicycle MIPS control unit: the FSM that drives the datapath's control inputs (today hand-driven by the datapath bench).
- Decodes opcode/func from the IR output; sequences fetch, decode, execute, memory and write-back.
- Produces every datapath control strobe plus memory mem_read/mem_write.
- Sits beside the datapath and memory in the CPU top.

Parameters:
- none (encodings below are fixed)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
opcode  input  6  IR[31:26]
func  input  6  IR[5:0]
zero  input  1  ALU zero flag from datapath (used by datapath PCWriteCon gating; monitored only)
PCWrite  output  1  unconditional PC load
PCWriteCon  output  1  PC load if zero (branch)
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
IR_write  output  1  instruction register load
RegDst  output  1  destination register: 0 = rt, 1 = rd
RegWrDst  output  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC into $31 (RegDst ignored)
reg_write  output  1  register file write enable
ALUSrcA  output  1  0 = PC, 1 = A
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
alu_op  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt
pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}, 11 = A

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including alu_op = 000, ALUSrcB = 00 and pc_src = 00.
  - First rising edge with rst = 1 moves IDLE -> FETCH.
- Outputs are Moore, decoded from the state register only. R_EXEC and I_EXEC alu_op additionally use func/opcode, which are stable from the IR after FETCH.
- Any output not listed for a state is 0.
- State outputs:
  - FETCH: mem_read, IorD=0, IR_write, ALUSrcA=0, ALUSrcB=01, alu_op=add, pc_src=00, PCWrite.
  - DECODE: ALUSrcA=0, ALUSrcB=11, alu_op=add (branch target into ALUOut).
  - MEM_ADR: ALUSrcA=1, ALUSrcB=10, add.
  - MEM_RD: mem_read, IorD=1.
  - MEM_WB: reg_write, RegDst=0, RegWrDst=01.
  - MEM_WR: mem_write, IorD=1.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, alu_op from func: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - R_WB: reg_write, RegDst=1, RegWrDst=00.
  - I_EXEC: ALUSrcA=1, ALUSrcB=10, alu_op = add (addi) or slt (slti).
  - I_WB: reg_write, RegDst=0, RegWrDst=00.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, alu_op=sub, PCWriteCon, pc_src=01.
  - JUMP: PCWrite, pc_src=10.
  - JAL: PCWrite, pc_src=10, reg_write, RegWrDst=10. The $31 write captures PC (already PC+4) on the same edge the PC loads.
  - JR: PCWrite, pc_src=11.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> by opcode:
    - 000000 with func in the R set -> R_EXEC.
    - 000000 with func 001000 -> JR.
    - 100011 (lw) or 101011 (sw) -> MEM_ADR.
    - 000100 (beq) -> BRANCH.
    - 001000 (addi) or 001010 (slti) -> I_EXEC.
    - 000010 (j) -> JUMP.
    - 000011 (jal) -> JAL.
    - Anything else (unsupported opcode or R func) -> FETCH, executed as a NOP; PC is already +4.
  - MEM_ADR -> MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD -> MEM_WB.
  - R_EXEC -> R_WB.
  - I_EXEC -> I_WB.
  - MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP, JAL, JR -> FETCH.
- Cycles per instruction (FETCH to next FETCH):
  - R-type, addi, slti, sw: 4.
  - lw: 5.
  - beq, j, jal, jr: 3.
  - Unsupported: 2.
- mem_read and mem_write are never asserted in the same cycle. reg_write and IR_write are never asserted together.
- Reset asserted mid-instruction: all outputs drop to 0 immediately (asynchronously); no partial write-back occurs after reset.
- Illegal or unreachable state encodings return to FETCH on the next edge with all outputs 0.

Test Plan:
- Hold rst=0 for 2 cycles -> every output 0. Release -> next edge in FETCH: mem_read=1, IR_write=1, PCWrite=1, ALUSrcB=01, alu_op=000.
- opcode=000000, func=100010 (sub) -> sequence FETCH, DECODE, R_EXEC (alu_op=001, ALUSrcA=1, ALUSrcB=00), R_WB (reg_write=1, RegDst=1, RegWrDst=00), then FETCH; 4 cycles.
- opcode=100011 (lw) -> MEM_ADR (ALUSrcB=10), MEM_RD (mem_read=1, IorD=1), MEM_WB (RegWrDst=01, RegDst=0); 5 cycles. Then opcode=101011 (sw) -> MEM_WR (mem_write=1, IorD=1); 4 cycles.
- opcode=000100 (beq) -> BRANCH cycle with PCWriteCon=1, pc_src=01, alu_op=001, PCWrite=0. Then opcode=000011 (jal) -> JAL cycle with PCWrite=1, pc_src=10, reg_write=1, RegWrDst=10.
- opcode=000000, func=001000 (jr) -> JR cycle with pc_src=11. Then opcode=111111 -> DECODE returns to FETCH in 2 cycles with no reg_write or mem_write.
- Pulse rst=0 for 5 ns during MEM_RD -> outputs 0 immediately. After release -> IDLE, then FETCH; no MEM_WB cycle occurs.
